// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   Sequenced MIPS control unit. Each instruction walks FETCH -> DECODE ->
//   EXEC -> MEM -> WB (skipping states it does not need), waiting on the
//   instruction/data memory ready handshakes. Adds an illegal-instruction
//   trap (or NOP), a memory timeout trap and a retired-instruction counter.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   op, func            IR[31:26], IR[5:0] (valid from DECODE onward)
//   z                   ALU zero flag, used by beq/bne in EXEC
//   imem_ready          instruction memory has data
//   dmem_ready          data access complete
//   imem_req, dmem_req  memory requests
//   pc_we, ir_we        PC / IR write enables
//   wreg .. wmem        datapath control bits
//   aluc                ALU operation
//   pcsrc               00 PC+4, 01 branch, 10 jr, 11 jump
//   illegal, bus_err    sticky trap causes
//   instret             retired-instruction count
//   state               FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 TRAP=7

module multicycle_control_unit #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32,
  parameter bit ILLEGAL_NOP = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             z,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             pc_we,
  output logic             ir_we,
  output logic             wreg,
  output logic             regrt,
  output logic             jal,
  output logic             m2reg,
  output logic             shift,
  output logic             aluimm,
  output logic             sext,
  output logic             wmem,
  output logic [3:0]       aluc,
  output logic [1:0]       pcsrc,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd7
  } state_t;

  // Wide enough to hold MEM_TIMEOUT; WAIT_LAST is the count at which a
  // further cycle without ready exhausts the budget.
  localparam int             WW        = $clog2(MEM_TIMEOUT + 2);
  localparam logic [WW-1:0]  WAIT_LAST = WW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t           cur_state, nxt_state;
  logic [WW-1:0]    wait_cnt;
  logic [CNT_W-1:0] cnt;
  logic             illegal_q, bus_err_q;

  logic       dec_valid, is_j, is_jal, is_jr, is_beq, is_bne, is_lw, is_sw;
  logic [3:0] f_aluc;
  logic       f_sext, f_regrt, f_aluimm, f_shift;
  logic       retire, set_illegal, set_bus_err, req_wait, wait_exp;

  // Instruction decoder: purely a function of the IR fields.
  always_comb begin
    dec_valid = 1'b0;
    is_j      = 1'b0;
    is_jal    = 1'b0;
    is_jr     = 1'b0;
    is_beq    = 1'b0;
    is_bne    = 1'b0;
    is_lw     = 1'b0;
    is_sw     = 1'b0;
    f_aluc    = 4'b0000;
    f_sext    = 1'b0;
    f_regrt   = 1'b0;
    f_aluimm  = 1'b0;
    f_shift   = 1'b0;
    if (op == 6'b000000) begin
      dec_valid = 1'b1;
      case (func)
        6'b100000: f_aluc = 4'b0000;
        6'b100010: f_aluc = 4'b0100;
        6'b100100: f_aluc = 4'b0001;
        6'b100101: f_aluc = 4'b0101;
        6'b100110: f_aluc = 4'b0010;
        6'b000000: begin f_aluc = 4'b0011; f_shift = 1'b1; end
        6'b000010: begin f_aluc = 4'b0111; f_shift = 1'b1; end
        6'b000011: begin f_aluc = 4'b1111; f_shift = 1'b1; end
        6'b001000: is_jr = 1'b1;
        default:   dec_valid = 1'b0;
      endcase
    end else begin
      dec_valid = 1'b1;
      case (op)
        6'b001000: begin f_sext = 1'b1; f_regrt = 1'b1; f_aluimm = 1'b1; end
        6'b001100: begin f_aluc = 4'b0001; f_regrt = 1'b1; f_aluimm = 1'b1; end
        6'b001101: begin f_aluc = 4'b0101; f_regrt = 1'b1; f_aluimm = 1'b1; end
        6'b001110: begin
          f_aluc = 4'b0010; f_sext = 1'b1; f_regrt = 1'b1; f_aluimm = 1'b1;
        end
        6'b001111: begin f_aluc = 4'b0110; f_regrt = 1'b1; f_aluimm = 1'b1; end
        6'b100011: begin
          is_lw = 1'b1; f_sext = 1'b1; f_regrt = 1'b1; f_aluimm = 1'b1;
        end
        // sw still needs the sign-extended offset on the ALU B input to
        // form its address, but writes no register so regrt stays 0.
        6'b101011: begin is_sw = 1'b1; f_sext = 1'b1; f_aluimm = 1'b1; end
        6'b000100: begin is_beq = 1'b1; f_aluc = 4'b0010; f_sext = 1'b1; end
        6'b000101: begin is_bne = 1'b1; f_aluc = 4'b0010; f_sext = 1'b1; end
        6'b000010: is_j = 1'b1;
        6'b000011: is_jal = 1'b1;
        default:   dec_valid = 1'b0;
      endcase
    end
  end

  // The wait counter only matters while a request is outstanding; reaching
  // WAIT_LAST with ready still low means this waiting cycle is the last one.
  assign wait_exp = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_LAST);

  // State register, wait counter, retire counter and sticky trap flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= FETCH;
      wait_cnt  <= '0;
      cnt       <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      if (nxt_state != cur_state)
        wait_cnt <= '0;
      else if (req_wait)
        wait_cnt <= wait_cnt + WW'(1);
      if (retire)
        cnt <= cnt + CNT_W'(1);
      if (set_illegal)
        illegal_q <= 1'b1;
      if (set_bus_err)
        bus_err_q <= 1'b1;
    end
  end

  // Next-state and output logic. Decoded fields are presented from DECODE
  // until the instruction leaves; enables only in the state that uses them.
  // Everything is forced low while rst is asserted so a reset mid-instruction
  // has no side effects in that cycle.
  always_comb begin
    nxt_state   = cur_state;
    retire      = 1'b0;
    set_illegal = 1'b0;
    set_bus_err = 1'b0;
    req_wait    = 1'b0;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    pc_we       = 1'b0;
    ir_we       = 1'b0;
    wreg        = 1'b0;
    regrt       = 1'b0;
    jal         = 1'b0;
    m2reg       = 1'b0;
    shift       = 1'b0;
    aluimm      = 1'b0;
    sext        = 1'b0;
    wmem        = 1'b0;
    aluc        = 4'b0000;
    pcsrc       = 2'b00;

    if (cur_state == DECODE || cur_state == EXEC || cur_state == MEM || cur_state == WB) begin
      aluc   = f_aluc;
      sext   = f_sext;
      regrt  = f_regrt;
      aluimm = f_aluimm;
      shift  = f_shift;
      m2reg  = is_lw;
    end

    case (cur_state)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          pc_we     = 1'b1;
          ir_we     = 1'b1;
          nxt_state = DECODE;
        end else begin
          req_wait = 1'b1;
          if (wait_exp) begin
            nxt_state   = TRAP;
            set_bus_err = 1'b1;
          end
        end
      end
      DECODE: begin
        if (!dec_valid) begin
          if (ILLEGAL_NOP) begin
            nxt_state = FETCH;
            retire    = 1'b1;
          end else begin
            nxt_state   = TRAP;
            set_illegal = 1'b1;
          end
        end else if (is_j || is_jal) begin
          pc_we     = 1'b1;
          pcsrc     = 2'b11;
          wreg      = is_jal;
          jal       = is_jal;
          nxt_state = FETCH;
          retire    = 1'b1;
        end else if (is_jr) begin
          pc_we     = 1'b1;
          pcsrc     = 2'b10;
          nxt_state = FETCH;
          retire    = 1'b1;
        end else begin
          nxt_state = EXEC;
        end
      end
      EXEC: begin
        if (is_beq || is_bne) begin
          pc_we     = is_beq ? z : !z;
          pcsrc     = (is_beq ? z : !z) ? 2'b01 : 2'b00;
          nxt_state = FETCH;
          retire    = 1'b1;
        end else if (is_lw || is_sw) begin
          nxt_state = MEM;
        end else begin
          nxt_state = WB;
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        wmem     = is_sw;
        if (dmem_ready) begin
          if (is_sw) begin
            nxt_state = FETCH;
            retire    = 1'b1;
          end else begin
            nxt_state = WB;
          end
        end else begin
          req_wait = 1'b1;
          if (wait_exp) begin
            nxt_state   = TRAP;
            set_bus_err = 1'b1;
          end
        end
      end
      WB: begin
        wreg      = 1'b1;
        nxt_state = FETCH;
        retire    = 1'b1;
      end
      TRAP:    nxt_state = TRAP;
      default: nxt_state = FETCH;
    endcase

    if (rst) begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      pc_we    = 1'b0;
      ir_we    = 1'b0;
      wreg     = 1'b0;
      regrt    = 1'b0;
      jal      = 1'b0;
      m2reg    = 1'b0;
      shift    = 1'b0;
      aluimm   = 1'b0;
      sext     = 1'b0;
      wmem     = 1'b0;
      aluc     = 4'b0000;
      pcsrc    = 2'b00;
    end
  end

  assign state   = rst ? 3'd0 : cur_state;
  assign instret = rst ? '0 : cnt;
  assign illegal = !rst && illegal_q;
  assign bus_err = !rst && bus_err_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit
//   Directed bench: a table of instructions run with zero-wait memory, then
//   hand-written sequences for waits, timeouts, traps, reset and wrap.
//   dut     : MEM_TIMEOUT=4, CNT_W=32, ILLEGAL_NOP=0
//   dut_nop : MEM_TIMEOUT=4, CNT_W=4,  ILLEGAL_NOP=1 (shares all inputs)

module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op, func;
  logic       z, imem_ready, dmem_ready;

  logic        imem_req, dmem_req, pc_we, ir_we, wreg, regrt, jal, m2reg;
  logic        shift, aluimm, sext, wmem, illegal, bus_err;
  logic [3:0]  aluc;
  logic [1:0]  pcsrc;
  logic [31:0] instret;
  logic [2:0]  state;

  logic        n_imem_req, n_dmem_req, n_pc_we, n_ir_we, n_wreg, n_regrt, n_jal, n_m2reg;
  logic        n_shift, n_aluimm, n_sext, n_wmem, n_illegal, n_bus_err;
  logic [3:0]  n_aluc;
  logic [1:0]  n_pcsrc;
  logic [3:0]  n_instret;
  logic [2:0]  n_state;

  multicycle_control_unit #(.MEM_TIMEOUT(4), .CNT_W(32), .ILLEGAL_NOP(1'b0)) dut (
    .clk(clk), .rst(rst), .op(op), .func(func), .z(z),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .pc_we(pc_we), .ir_we(ir_we),
    .wreg(wreg), .regrt(regrt), .jal(jal), .m2reg(m2reg), .shift(shift),
    .aluimm(aluimm), .sext(sext), .wmem(wmem), .aluc(aluc), .pcsrc(pcsrc),
    .illegal(illegal), .bus_err(bus_err), .instret(instret), .state(state)
  );

  multicycle_control_unit #(.MEM_TIMEOUT(4), .CNT_W(4), .ILLEGAL_NOP(1'b1)) dut_nop (
    .clk(clk), .rst(rst), .op(op), .func(func), .z(z),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(n_imem_req), .dmem_req(n_dmem_req), .pc_we(n_pc_we), .ir_we(n_ir_we),
    .wreg(n_wreg), .regrt(n_regrt), .jal(n_jal), .m2reg(n_m2reg), .shift(n_shift),
    .aluimm(n_aluimm), .sext(n_sext), .wmem(n_wmem), .aluc(n_aluc), .pcsrc(n_pcsrc),
    .illegal(n_illegal), .bus_err(n_bus_err), .instret(n_instret), .state(n_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] func;
    logic       z;
    int         lat;
    logic [3:0] aluc;
    logic       sext, regrt, aluimm, shift;
    int         wregs;
    int         late_pcwe;
    logic [1:0] late_pcsrc;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock and let outputs settle away from the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [5:0] o, input logic [5:0] f, input logic zz,
                               input logic ir, input logic dr);
    op = o; func = f; z = zz; imem_ready = ir; dmem_ready = dr;
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  function automatic vec_t mk(input string nm, input logic [5:0] o, input logic [5:0] f,
                              input logic zz, input int lt, input logic [3:0] ac,
                              input logic se, input logic rt, input logic ai, input logic sh,
                              input int wr, input int pw, input logic [1:0] ps);
    vec_t v;
    v.name = nm; v.op = o; v.func = f; v.z = zz; v.lat = lt; v.aluc = ac;
    v.sext = se; v.regrt = rt; v.aluimm = ai; v.shift = sh;
    v.wregs = wr; v.late_pcwe = pw; v.late_pcsrc = ps;
    return v;
  endfunction

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs [21];
    int   exp_cnt;
    int   cyc, wregs, late_pcwe, reqs, mem_seen;
    logic [1:0] late_pcsrc;
    logic [3:0] d_aluc, last_aluc;
    logic d_sext, d_regrt, d_aluimm, d_shift, f_pcwe, f_irwe;
    logic wb_m2reg, wb_regrt, wb_sext, wb_wreg, wmem_seen;

    vecs[0]  = mk("add",   6'b000000, 6'b100000, 0, 4, 4'b0000, 0, 0, 0, 0, 1, 0, 2'b00);
    vecs[1]  = mk("sub",   6'b000000, 6'b100010, 0, 4, 4'b0100, 0, 0, 0, 0, 1, 0, 2'b00);
    vecs[2]  = mk("and",   6'b000000, 6'b100100, 0, 4, 4'b0001, 0, 0, 0, 0, 1, 0, 2'b00);
    vecs[3]  = mk("or",    6'b000000, 6'b100101, 0, 4, 4'b0101, 0, 0, 0, 0, 1, 0, 2'b00);
    vecs[4]  = mk("xor",   6'b000000, 6'b100110, 0, 4, 4'b0010, 0, 0, 0, 0, 1, 0, 2'b00);
    vecs[5]  = mk("sll",   6'b000000, 6'b000000, 0, 4, 4'b0011, 0, 0, 0, 1, 1, 0, 2'b00);
    vecs[6]  = mk("srl",   6'b000000, 6'b000010, 0, 4, 4'b0111, 0, 0, 0, 1, 1, 0, 2'b00);
    vecs[7]  = mk("sra",   6'b000000, 6'b000011, 0, 4, 4'b1111, 0, 0, 0, 1, 1, 0, 2'b00);
    vecs[8]  = mk("addi",  6'b001000, 6'b101010, 0, 4, 4'b0000, 1, 1, 1, 0, 1, 0, 2'b00);
    vecs[9]  = mk("andi",  6'b001100, 6'b101010, 0, 4, 4'b0001, 0, 1, 1, 0, 1, 0, 2'b00);
    vecs[10] = mk("ori",   6'b001101, 6'b101010, 0, 4, 4'b0101, 0, 1, 1, 0, 1, 0, 2'b00);
    vecs[11] = mk("xori",  6'b001110, 6'b101010, 0, 4, 4'b0010, 1, 1, 1, 0, 1, 0, 2'b00);
    vecs[12] = mk("lui",   6'b001111, 6'b101010, 0, 4, 4'b0110, 0, 1, 1, 0, 1, 0, 2'b00);
    vecs[13] = mk("lw",    6'b100011, 6'b101010, 0, 5, 4'b0000, 1, 1, 1, 0, 1, 0, 2'b00);
    vecs[14] = mk("beq_t", 6'b000100, 6'b101010, 1, 3, 4'b0010, 1, 0, 0, 0, 0, 1, 2'b01);
    vecs[15] = mk("beq_n", 6'b000100, 6'b101010, 0, 3, 4'b0010, 1, 0, 0, 0, 0, 0, 2'b00);
    vecs[16] = mk("bne_n", 6'b000101, 6'b101010, 1, 3, 4'b0010, 1, 0, 0, 0, 0, 0, 2'b00);
    vecs[17] = mk("bne_t", 6'b000101, 6'b101010, 0, 3, 4'b0010, 1, 0, 0, 0, 0, 1, 2'b01);
    vecs[18] = mk("j",     6'b000010, 6'b101010, 0, 2, 4'b0000, 0, 0, 0, 0, 0, 1, 2'b11);
    vecs[19] = mk("jal",   6'b000011, 6'b101010, 0, 2, 4'b0000, 0, 0, 0, 0, 1, 1, 2'b11);
    vecs[20] = mk("jr",    6'b000000, 6'b001000, 0, 2, 4'b0000, 0, 0, 0, 0, 0, 1, 2'b10);

    // Reset: every output low while rst is held, even with ready high.
    rst = 1'b1;
    applyStimulus(6'b000000, 6'b100000, 1'b0, 1'b1, 1'b1);
    tick();
    checkOutput("rst.imem_req", imem_req, 0);
    checkOutput("rst.pc_we", pc_we, 0);
    checkOutput("rst.ir_we", ir_we, 0);
    checkOutput("rst.state", state, 0);
    checkOutput("rst.instret", instret, 0);
    rst = 1'b0;
    #1;
    checkOutput("rst.release_state", state, 0);
    checkOutput("rst.release_imem_req", imem_req, 1);

    // Table: zero-wait memory, one instruction per entry.
    exp_cnt = 0;
    for (int i = 0; i < 21; i++) begin
      cyc = 0; wregs = 0; late_pcwe = 0; late_pcsrc = 2'b00;
      d_aluc = 4'hx; last_aluc = 4'hx;
      d_sext = 1'bx; d_regrt = 1'bx; d_aluimm = 1'bx; d_shift = 1'bx;
      f_pcwe = 1'b0; f_irwe = 1'b0;
      do begin
        applyStimulus(vecs[i].op, vecs[i].func, vecs[i].z, 1'b1, 1'b1);
        if (cyc == 0) begin f_pcwe = pc_we; f_irwe = ir_we; end
        if (state == 3'd1) begin
          d_aluc = aluc; d_sext = sext; d_regrt = regrt; d_aluimm = aluimm; d_shift = shift;
        end
        if (state != 3'd0) begin
          if (pc_we) late_pcwe++;
          if (pcsrc != 2'b00) late_pcsrc = pcsrc;
          last_aluc = aluc;
        end
        if (wreg) wregs++;
        cyc++;
        tick();
      end while (state != 3'd0 && cyc < 12);
      exp_cnt++;
      checkOutput($sformatf("%s.latency", vecs[i].name), cyc, vecs[i].lat);
      checkOutput($sformatf("%s.fetch_pc_we", vecs[i].name), f_pcwe, 1);
      checkOutput($sformatf("%s.fetch_ir_we", vecs[i].name), f_irwe, 1);
      checkOutput($sformatf("%s.aluc", vecs[i].name), d_aluc, vecs[i].aluc);
      checkOutput($sformatf("%s.aluc_last", vecs[i].name), last_aluc, vecs[i].aluc);
      checkOutput($sformatf("%s.sext", vecs[i].name), d_sext, vecs[i].sext);
      checkOutput($sformatf("%s.regrt", vecs[i].name), d_regrt, vecs[i].regrt);
      checkOutput($sformatf("%s.aluimm", vecs[i].name), d_aluimm, vecs[i].aluimm);
      checkOutput($sformatf("%s.shift", vecs[i].name), d_shift, vecs[i].shift);
      checkOutput($sformatf("%s.wreg_cycles", vecs[i].name), wregs, vecs[i].wregs);
      checkOutput($sformatf("%s.late_pc_we", vecs[i].name), late_pcwe, vecs[i].late_pcwe);
      checkOutput($sformatf("%s.late_pcsrc", vecs[i].name), late_pcsrc, vecs[i].late_pcsrc);
      checkOutput($sformatf("%s.instret", vecs[i].name), instret, exp_cnt);
    end

    // sw with data memory stalled; reset lands in the middle of MEM.
    cyc = 0;
    applyStimulus(6'b101011, 6'b000000, 1'b0, 1'b1, 1'b0);
    while (state != 3'd3 && cyc < 8) begin
      tick();
      cyc++;
    end
    checkOutput("swmid.reach_mem", state, 3);
    checkOutput("swmid.dmem_req", dmem_req, 1);
    checkOutput("swmid.wmem", wmem, 1);
    tick();
    rst = 1'b1;
    applyStimulus(6'b101011, 6'b000000, 1'b0, 1'b1, 1'b1);
    checkOutput("swmid.rst_dmem_req", dmem_req, 0);
    checkOutput("swmid.rst_wmem", wmem, 0);
    checkOutput("swmid.rst_pc_we", pc_we, 0);
    checkOutput("swmid.rst_state", state, 0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("swmid.after_state", state, 0);
    checkOutput("swmid.after_instret", instret, 0);
    checkOutput("swmid.after_bus_err", bus_err, 0);
    checkOutput("swmid.after_illegal", illegal, 0);

    // lw whose data ready arrives in the 4th MEM cycle (== MEM_TIMEOUT).
    cyc = 0; reqs = 0; mem_seen = 0; wmem_seen = 1'b0;
    wb_m2reg = 1'b0; wb_regrt = 1'b0; wb_sext = 1'b0; wb_wreg = 1'b0;
    do begin
      applyStimulus(6'b100011, 6'b000000, 1'b0, 1'b1, (state == 3'd3) && (mem_seen == 3));
      if (dmem_req) reqs++;
      if (state == 3'd3) begin
        mem_seen++;
        if (wmem) wmem_seen = 1'b1;
      end
      if (state == 3'd4) begin
        wb_m2reg = m2reg; wb_regrt = regrt; wb_sext = sext; wb_wreg = wreg;
      end
      cyc++;
      tick();
    end while (state != 3'd0 && cyc < 20);
    checkOutput("lwwait.cycles", cyc, 8);
    checkOutput("lwwait.dmem_req_cycles", reqs, 4);
    checkOutput("lwwait.wmem", wmem_seen, 0);
    checkOutput("lwwait.wb_m2reg", wb_m2reg, 1);
    checkOutput("lwwait.wb_regrt", wb_regrt, 1);
    checkOutput("lwwait.wb_sext", wb_sext, 1);
    checkOutput("lwwait.wb_wreg", wb_wreg, 1);
    checkOutput("lwwait.bus_err", bus_err, 0);
    checkOutput("lwwait.instret", instret, 1);

    // Instruction memory never ready: trap after 4 waiting cycles.
    cyc = 0; reqs = 0;
    applyStimulus(6'b000000, 6'b100000, 1'b0, 1'b0, 1'b0);
    while (state == 3'd0 && cyc < 10) begin
      if (imem_req) reqs++;
      tick();
      cyc++;
    end
    checkOutput("tmo.imem_req_cycles", reqs, 4);
    checkOutput("tmo.state", state, 7);
    checkOutput("tmo.bus_err", bus_err, 1);
    checkOutput("tmo.illegal", illegal, 0);
    applyStimulus(6'b000000, 6'b100000, 1'b0, 1'b1, 1'b1);
    tick();
    tick();
    checkOutput("tmo.stuck_state", state, 7);
    checkOutput("tmo.stuck_imem_req", imem_req, 0);
    checkOutput("tmo.stuck_pc_we", pc_we, 0);
    checkOutput("tmo.sticky_bus_err", bus_err, 1);

    // Undecoded op: dut traps, dut_nop retires it as a NOP.
    doReset();
    applyStimulus(6'b111111, 6'b000000, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("ill.decode_state", state, 1);
    checkOutput("ill.decode_pc_we", pc_we, 0);
    tick();
    checkOutput("ill.trap_state", state, 7);
    checkOutput("ill.illegal", illegal, 1);
    checkOutput("ill.instret", instret, 0);
    checkOutput("ill.nop_state", n_state, 0);
    checkOutput("ill.nop_instret", n_instret, 1);
    checkOutput("ill.nop_illegal", n_illegal, 0);
    reqs = 0;
    for (int k = 0; k < 4; k++) begin
      if (imem_req) reqs++;
      tick();
    end
    checkOutput("ill.trap_imem_req_cycles", reqs, 0);
    checkOutput("ill.trap_state_hold", state, 7);
    checkOutput("ill.nop_instret_later", n_instret, 3);

    // 16 jumps: the 4-bit counter wraps to 0, the 32-bit one reads 16.
    doReset();
    applyStimulus(6'b000010, 6'b000000, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 32; k++) tick();
    checkOutput("wrap.state", state, 0);
    checkOutput("wrap.instret32", instret, 16);
    checkOutput("wrap.instret4", n_instret, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
